// File: rtl/alu_control_sequencer_if.sv
// Control bus between the microstep sequencer and the SAP datapath/ALU.
// Carries the opcode and ALU flags in, and every load/drive strobe out.
// master = sequencer side, slave = datapath side.
interface alu_control_sequencer_if;
    logic [3:0] opcode;
    logic [1:0] flag_in;
    logic [2:0] step;
    logic       halted;
    logic       hlt;
    logic       mi;
    logic       ri;
    logic       ro;
    logic       io;
    logic       ii;
    logic       ai;
    logic       ao;
    logic       bi;
    logic       oi;
    logic       ce;
    logic       co;
    logic       j;
    logic       eo_n;
    logic       su;
    logic       fi_n;

    modport master (
        input  opcode, flag_in,
        output step, halted, hlt, mi, ri, ro, io, ii, ai, ao, bi, oi,
               ce, co, j, eo_n, su, fi_n
    );

    modport slave (
        output opcode, flag_in,
        input  step, halted, hlt, mi, ri, ro, io, ii, ai, ao, bi, oi,
               ce, co, j, eo_n, su, fi_n
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// Microstep sequencer and instruction decoder driving SAP bus strobes and ALU controls.
// Latency: strobes are a zero-latency decode of the current step; step advances every edge.
// No backpressure: runs free until HLT, then freezes with hlt asserted until clr.
module alu_control_sequencer #(
    parameter int STEPS      = 5,
    parameter int FLAG_C_BIT = 1,
    parameter int FLAG_Z_BIT = 0
) (
    input  logic                        clk,
    input  logic                        clr,
    alu_control_sequencer_if.master     bus
);

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;

    // State and step registers; clr wins over halt and every other event.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RUN;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Next state: step wraps at LAST_STEP; HLT in T2 enters the halted state, which freezes step.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (state_q == ST_RUN) begin
            step_d = (step_q == LAST_STEP) ? 3'd0 : step_q + 3'd1;
            if (step_q == 3'd2 && bus.opcode == OP_HLT) begin
                state_d = ST_HALT;
            end
        end
    end

    assign bus.step   = step_q;
    assign bus.halted = (state_q == ST_HALT);

    // Strobe decode from {step, opcode, flags, halted}; clr forces everything inactive.
    always_comb begin
        bus.hlt  = 1'b0;
        bus.mi   = 1'b0;
        bus.ri   = 1'b0;
        bus.ro   = 1'b0;
        bus.io   = 1'b0;
        bus.ii   = 1'b0;
        bus.ai   = 1'b0;
        bus.ao   = 1'b0;
        bus.bi   = 1'b0;
        bus.oi   = 1'b0;
        bus.ce   = 1'b0;
        bus.co   = 1'b0;
        bus.j    = 1'b0;
        bus.eo_n = 1'b1;
        bus.su   = 1'b0;
        bus.fi_n = 1'b1;
        if (!clr) begin
            if (state_q == ST_HALT) begin
                bus.hlt = 1'b1;
            end else begin
                case (step_q)
                    3'd0: begin
                        bus.co = 1'b1;
                        bus.mi = 1'b1;
                    end
                    3'd1: begin
                        bus.ro = 1'b1;
                        bus.ii = 1'b1;
                        bus.ce = 1'b1;
                    end
                    3'd2: begin
                        case (bus.opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                bus.io = 1'b1;
                                bus.mi = 1'b1;
                            end
                            OP_LDI: begin
                                bus.io = 1'b1;
                                bus.ai = 1'b1;
                            end
                            OP_JMP: begin
                                bus.io = 1'b1;
                                bus.j  = 1'b1;
                            end
                            // Conditional jumps see the flags latched by the last ADD/SUB.
                            OP_JC: begin
                                bus.io = bus.flag_in[FLAG_C_BIT];
                                bus.j  = bus.flag_in[FLAG_C_BIT];
                            end
                            OP_JZ: begin
                                bus.io = bus.flag_in[FLAG_Z_BIT];
                                bus.j  = bus.flag_in[FLAG_Z_BIT];
                            end
                            OP_OUT: begin
                                bus.ao = 1'b1;
                                bus.oi = 1'b1;
                            end
                            OP_HLT: begin
                                bus.hlt = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    3'd3: begin
                        case (bus.opcode)
                            OP_LDA: begin
                                bus.ro = 1'b1;
                                bus.ai = 1'b1;
                            end
                            OP_ADD, OP_SUB: begin
                                bus.ro = 1'b1;
                                bus.bi = 1'b1;
                            end
                            OP_STA: begin
                                bus.ao = 1'b1;
                                bus.ri = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    3'd4: begin
                        // ALU result onto the bus into A; flags latch at the end of this step.
                        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                            bus.eo_n = 1'b0;
                            bus.ai   = 1'b1;
                            bus.fi_n = 1'b0;
                            bus.su   = (bus.opcode == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
